// File: rtl/banco_fifo_entrada_pkg.sv
// Shared transaction-layer types for the input buffer bank: word widths, lane count and the stored entry layout.
// Latency: n/a (types only). Backpressure: n/a.
package pkg_capa_transaccion;

    localparam int WORD_W    = 8;
    localparam int DEST_W    = 4;
    localparam int NUM_LANES = 4;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [WORD_W-1:0] data;
    } entrada_t;

endpackage

// File: rtl/banco_fifo_entrada_fifo_carril.sv
// One input lane: DEPTH-entry FIFO with registered read port, count-decoded flags and a sticky error flag.
// Latency: 1 cycle push-to-poppable, 1 cycle pop-to-valid_out. Backpressure: overflow drops the word, underflow is ignored; both set error.
module fifo_carril
    import pkg_capa_transaccion::*;
#(
    parameter int DEPTH = 8,
    parameter int AF_TH = 6,
    parameter int AE_TH = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [WORD_W-1:0] data_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic              pop,
    output logic [WORD_W-1:0] data_out,
    output logic [DEST_W-1:0] dest_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

    entrada_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              pop_ok;
    logic              push_ok;

    // A pop in the same cycle frees a slot, so a full lane still accepts the push.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != DEPTH_C) || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{dest: dest_in, data: data_in};
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            dest_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr].data;
                dest_out <= mem[rd_ptr].dest;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if ((push && !push_ok) || (pop && !pop_ok)) begin
                error <= 1'b1;
            end
        end
    end

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

endmodule

// File: rtl/banco_fifo_entrada.sv
// Four independent input lanes feeding the lane arbiter; ports flattened to per-lane _0.._3 names.
// Latency: 1 cycle per lane for push and pop. Backpressure: none upstream; overflow/underflow reported on errorN.
module banco_fifo_entrada
    import pkg_capa_transaccion::*;
#(
    parameter int DEPTH = 8,
    parameter int AF_TH = 6,
    parameter int AE_TH = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push0, push1, push2, push3,
    input  logic [WORD_W-1:0] data_in0, data_in1, data_in2, data_in3,
    input  logic [DEST_W-1:0] dest_in0, dest_in1, dest_in2, dest_in3,
    input  logic              pop0, pop1, pop2, pop3,
    output logic [WORD_W-1:0] data_out0, data_out1, data_out2, data_out3,
    output logic [DEST_W-1:0] dest_out0, dest_out1, dest_out2, dest_out3,
    output logic              valid_out0, valid_out1, valid_out2, valid_out3,
    output logic              full0, full1, full2, full3,
    output logic              empty0, empty1, empty2, empty3,
    output logic              almost_full0, almost_full1, almost_full2, almost_full3,
    output logic              almost_empty0, almost_empty1, almost_empty2, almost_empty3,
    output logic              error0, error1, error2, error3
);

    fifo_carril #(.DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_carril0 (
        .clk(clk), .reset_L(reset_L), .push(push0), .data_in(data_in0), .dest_in(dest_in0),
        .pop(pop0), .data_out(data_out0), .dest_out(dest_out0), .valid_out(valid_out0),
        .full(full0), .empty(empty0), .almost_full(almost_full0),
        .almost_empty(almost_empty0), .error(error0)
    );

    fifo_carril #(.DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_carril1 (
        .clk(clk), .reset_L(reset_L), .push(push1), .data_in(data_in1), .dest_in(dest_in1),
        .pop(pop1), .data_out(data_out1), .dest_out(dest_out1), .valid_out(valid_out1),
        .full(full1), .empty(empty1), .almost_full(almost_full1),
        .almost_empty(almost_empty1), .error(error1)
    );

    fifo_carril #(.DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_carril2 (
        .clk(clk), .reset_L(reset_L), .push(push2), .data_in(data_in2), .dest_in(dest_in2),
        .pop(pop2), .data_out(data_out2), .dest_out(dest_out2), .valid_out(valid_out2),
        .full(full2), .empty(empty2), .almost_full(almost_full2),
        .almost_empty(almost_empty2), .error(error2)
    );

    fifo_carril #(.DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_carril3 (
        .clk(clk), .reset_L(reset_L), .push(push3), .data_in(data_in3), .dest_in(dest_in3),
        .pop(pop3), .data_out(data_out3), .dest_out(dest_out3), .valid_out(valid_out3),
        .full(full3), .empty(empty3), .almost_full(almost_full3),
        .almost_empty(almost_empty3), .error(error3)
    );

endmodule

// File: tb/tb_banco_fifo_entrada.sv
// Bench for the four-lane input buffer: queue-based lane model, scoreboard of expected pops, negedge monitor.
module tb_banco_fifo_entrada;

    localparam int DEPTH = 8;
    localparam int AF_TH = 6;
    localparam int AE_TH = 2;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] push, pop;
    logic [7:0] din  [4];
    logic [3:0] dst  [4];
    logic [7:0] dout [4];
    logic [3:0] dsto [4];
    logic [3:0] vout, full, empty, afull, aempty, err;

    int checks = 0;
    int errors = 0;

    // Lane model: contents in order, sticky error, and the scoreboard of words due on the next cycle.
    logic [11:0] lane_q [4][$];
    logic [11:0] exp_q  [4][$];
    logic [11:0] last_out [4];
    logic        err_m [4];

    always #5 clk = ~clk;

    banco_fifo_entrada #(.DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
        .clk(clk), .reset_L(reset_L),
        .push0(push[0]), .push1(push[1]), .push2(push[2]), .push3(push[3]),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .dest_in0(dst[0]), .dest_in1(dst[1]), .dest_in2(dst[2]), .dest_in3(dst[3]),
        .pop0(pop[0]), .pop1(pop[1]), .pop2(pop[2]), .pop3(pop[3]),
        .data_out0(dout[0]), .data_out1(dout[1]), .data_out2(dout[2]), .data_out3(dout[3]),
        .dest_out0(dsto[0]), .dest_out1(dsto[1]), .dest_out2(dsto[2]), .dest_out3(dsto[3]),
        .valid_out0(vout[0]), .valid_out1(vout[1]), .valid_out2(vout[2]), .valid_out3(vout[3]),
        .full0(full[0]), .full1(full[1]), .full2(full[2]), .full3(full[3]),
        .empty0(empty[0]), .empty1(empty[1]), .empty2(empty[2]), .empty3(empty[3]),
        .almost_full0(afull[0]), .almost_full1(afull[1]),
        .almost_full2(afull[2]), .almost_full3(afull[3]),
        .almost_empty0(aempty[0]), .almost_empty1(aempty[1]),
        .almost_empty2(aempty[2]), .almost_empty3(aempty[3]),
        .error0(err[0]), .error1(err[1]), .error2(err[2]), .error3(err[3])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int l = 0; l < 4; l++) begin
            lane_q[l].delete();
            exp_q[l].delete();
            last_out[l] = '0;
            err_m[l]    = 1'b0;
        end
    endtask

    task automatic check_reset_values();
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("rst_l%0d_out", l), {dsto[l], dout[l]}, 0);
            chk($sformatf("rst_l%0d_valid", l), vout[l], 0);
            chk($sformatf("rst_l%0d_empty", l), empty[l], 1);
            chk($sformatf("rst_l%0d_aempty", l), aempty[l], 1);
            chk($sformatf("rst_l%0d_full", l), full[l], 0);
            chk($sformatf("rst_l%0d_afull", l), afull[l], 0);
            chk($sformatf("rst_l%0d_error", l), err[l], 0);
        end
    endtask

    // Reference model: applies each lane's rules to the inputs seen at the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset_L) begin
                for (int l = 0; l < 4; l++) begin
                    int  n;
                    bit  pop_ok, push_ok;
                    n       = lane_q[l].size();
                    pop_ok  = pop[l] && (n > 0);
                    push_ok = push[l] && ((n < DEPTH) || pop_ok);
                    if ((pop[l] && !pop_ok) || (push[l] && !push_ok)) err_m[l] = 1'b1;
                    if (pop_ok) exp_q[l].push_back(lane_q[l].pop_front());
                    if (push_ok) lane_q[l].push_back({dst[l], din[l]});
                end
            end
        end
    end

    // Monitor: consumes the scoreboard whenever a lane presents valid_out, and checks flags/hold.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_L) begin
                for (int l = 0; l < 4; l++) begin
                    int n;
                    bit expv;
                    n    = lane_q[l].size();
                    expv = (exp_q[l].size() > 0);
                    chk($sformatf("l%0d_valid", l), vout[l], expv);
                    if (expv) last_out[l] = exp_q[l].pop_front();
                    chk($sformatf("l%0d_out", l), {dsto[l], dout[l]}, last_out[l]);
                    chk($sformatf("l%0d_full", l), full[l], n == DEPTH);
                    chk($sformatf("l%0d_empty", l), empty[l], n == 0);
                    chk($sformatf("l%0d_afull", l), afull[l], n >= AF_TH);
                    chk($sformatf("l%0d_aempty", l), aempty[l], n <= AE_TH);
                    chk($sformatf("l%0d_error", l), err[l], err_m[l]);
                end
            end
        end
    end

    // Drive one cycle's push/pop masks; data inputs are set by the caller beforehand.
    task automatic cyc(input logic [3:0] pu, input logic [3:0] po);
        push = pu;
        pop  = po;
        @(negedge clk);
    endtask

    task automatic put(input int l, input logic [3:0] d, input logic [7:0] v);
        dst[l] = d;
        din[l] = v;
    endtask

    initial begin
        reset_L = 1'b0;
        push = '0;
        pop  = '0;
        for (int l = 0; l < 4; l++) put(l, 4'h0, 8'h00);
        clear_model();
        #1;
        check_reset_values();
        @(negedge clk);
        reset_L = 1'b1;
        cyc(4'b0000, 4'b0000);

        // Lane 0: two words in, two out.
        put(0, 4'd2, 8'hA5); cyc(4'b0001, 4'b0000);
        put(0, 4'd1, 8'h3C); cyc(4'b0001, 4'b0000);
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b0000);
        chk("t1_empty0", empty[0], 1);

        // Lane 1: fill, overflow, drain.
        for (int i = 0; i < 9; i++) begin
            put(1, 4'(i), 8'(8'h40 + i));
            cyc(4'b0010, 4'b0000);
        end
        chk("t2_full1", full[1], 1);
        chk("t2_error1", err[1], 1);
        for (int i = 0; i < 8; i++) cyc(4'b0000, 4'b0010);
        cyc(4'b0000, 4'b0000);

        // Lane 2: full with simultaneous push/pop.
        for (int i = 0; i < 8; i++) begin
            put(2, 4'd3, 8'(8'h20 + i));
            cyc(4'b0100, 4'b0000);
        end
        put(2, 4'd7, 8'h77); cyc(4'b0100, 4'b0100);
        chk("t3_full2", full[2], 1);
        for (int i = 0; i < 8; i++) cyc(4'b0000, 4'b0100);
        cyc(4'b0000, 4'b0000);

        // Lane 3: pop on empty with a push in the same cycle.
        put(3, 4'd5, 8'h11); cyc(4'b1000, 4'b1000);
        chk("t4_valid3", vout[3], 0);
        chk("t4_error3", err[3], 1);
        chk("t4_empty3", empty[3], 0);
        cyc(4'b0000, 4'b1000);
        cyc(4'b0000, 4'b0000);

        // Lane 0: wrap the pointers, then reset mid-stream.
        for (int i = 0; i < 5; i++) begin
            put(0, 4'd9, 8'(8'h50 + i));
            cyc(4'b0001, 4'b0000);
        end
        for (int i = 0; i < 8; i++) begin
            put(0, 4'd6, 8'(8'h60 + i));
            cyc(4'b0001, (i % 2 == 0) ? 4'b0001 : 4'b0000);
        end
        put(0, 4'd4, 8'h99);
        push = 4'b0001;
        pop  = 4'b0001;
        @(posedge clk);
        #2;
        reset_L = 1'b0;
        push = '0;
        pop  = '0;
        clear_model();
        #1;
        check_reset_values();
        @(negedge clk);
        reset_L = 1'b1;
        put(0, 4'd8, 8'hE1); cyc(4'b0001, 4'b0000);
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b0000);

        // All lanes at once with distinct data.
        for (int l = 0; l < 4; l++) put(l, 4'(l), 8'(8'h10 + l));
        cyc(4'b1111, 4'b0000);
        cyc(4'b0000, 4'b1111);
        for (int l = 0; l < 4; l++) chk($sformatf("t6_data%0d", l), dout[l], 8'h10 + l);
        cyc(4'b0000, 4'b0000);

        // Random traffic on all lanes.
        for (int c = 0; c < 2000; c++) begin
            for (int l = 0; l < 4; l++) put(l, 4'($urandom), 8'($urandom));
            cyc(4'($urandom), 4'($urandom));
        end
        cyc(4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_fifo_entrada.md
# banco_fifo_entrada

Four-lane input buffer that sits directly upstream of the lane arbiter. Each lane stores incoming {destination, data} words in its own FIFO and releases one word per pop. Each lane reports full, empty, almost-full, almost-empty and a sticky error flag. The arbiter drives the pops and consumes the registered outputs; the transaction source drives the pushes.

## Interface
- `DEPTH`, 8: entries per lane; must be a power of two, ≥4.
- `AF_TH`, 6: almost_full asserted when count ≥ AF_TH.
- `AE_TH`, 2: almost_empty asserted when count ≤ AE_TH.
- `clk` input 1: single clock, all state on rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `push0..push3` input 1 each: write request, lane N.
- `data_in0..data_in3` input 8 each: payload, lane N.
- `dest_in0..dest_in3` input 4 each: destination tag, lane N.
- `pop0..pop3` input 1 each: read request, lane N.
- `data_out0..data_out3` output 8 each: registered read payload, lane N.
- `dest_out0..dest_out3` output 4 each: registered read destination, lane N.
- `valid_out0..valid_out3` output 1 each: data_outN/dest_outN hold a freshly popped word this cycle.
- `full0..3`, `empty0..3`, `almost_full0..3`, `almost_empty0..3` output 1 each: status, lane N.
- `error0..error3` output 1 each: sticky overflow/underflow indication, lane N.

## Operation
- Lanes are fully independent; the behaviour below applies per lane.
- Storage: DEPTH × 12-bit entries, entry = {dest[3:0], data[7:0]}.
- Pointers: wr_ptr and rd_ptr, log2(DEPTH) bits, wrap DEPTH-1 → 0 naturally.
- count: log2(DEPTH)+1 bits, range 0..DEPTH.
- Push accepted when push=1 and (count<DEPTH or pop accepted same cycle): write mem[wr_ptr], wr_ptr+1.
- Pop accepted when pop=1 and count>0: data_out/dest_out ← mem[rd_ptr], valid_out=1 next cycle, rd_ptr+1.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push rejected (full, no accepted pop): word dropped, nothing changes except error←1.
- Pop on empty: ignored, valid_out=0, data_out/dest_out hold, error←1. A simultaneous push is still accepted; the word is not bypassed and becomes readable next cycle.
- Push+pop on full: both accepted, count stays DEPTH.
- Flags are decoded from registered count:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count≥AF_TH)
  - almost_empty = (count≤AE_TH)
- error is cleared only by reset.
- data_out/dest_out hold their last value when no pop is accepted.

## Timing
- Reset values (asynchronous, immediate on reset_L=0):
  - data_out=0, dest_out=0, valid_out=0
  - empty=1, almost_empty=1, full=0, almost_full=0, error=0
  - pointers=0, count=0
  - memory contents are don't-care.
- Reset mid-operation discards all stored words; the first push after release lands at address 0.
- Write latency: a word pushed at edge k is poppable at edge k+1; empty deasserts after edge k.
- Read latency: a pop accepted at edge k presents the word on data_out/valid_out after edge k, for one cycle.
- Back-to-back pops stream one word per cycle with valid_out held high.
- Flags change only after a clock edge; there is no combinational path from push/pop to any flag.

## Structure
- Shared package `pkg_capa_transaccion`:
  - constants `WORD_W=8`, `DEST_W=4`, `NUM_LANES=4`
  - typedef `entrada_t` (packed {dest, data}).
- Sub-module `fifo_carril`: one lane with DEPTH/AF_TH/AE_TH parameters.
- Top level instantiates four `fifo_carril` and flattens ports to the _0.._3 names.

## Test plan
- Reset, then push lane0 words (dest=2, data=0xA5), (dest=1, data=0x3C); pop twice → data_out0=0xA5/dest_out0=2 then 0x3C/1, valid_out0 high two cycles, empty0=1 after.
- Push 8 words into lane1 → full1=1, almost_full1=1 from the 6th push; 9th push → error1=1, count stays 8; pops return the first 8 words in order.
- Lane2 full, push 0x77 with pop same cycle → full2 stays 1, oldest word out, 0x77 becomes last entry.
- Pop lane3 while empty, with push 0x11 same cycle → valid_out3=0, error3=1, empty3=0 next cycle; the following pop returns 0x11.
- Fill lane0 with 5 words, fill lane0 past the wrap (write 8 more with interleaved pops), assert reset_L=0 mid-stream → all outputs at reset values immediately; post-reset push/pop returns the new word only.
- All four lanes push/pop simultaneously with distinct data (0x10+N) → no cross-lane interference; each data_outN=0x10+N.
